spi_frame_counter: RTL
======================

# spi_frame_counter

Parametrised bit/word/frame counter for the MCU SPI block, the successor to the fixed 4-bit byte counter. It counts shifted bits within a word of BIT_W bits and words within a frame of programmable length, and raises registered word-done and frame-done strobes. It runs in one-shot or continuous mode. It sits between the SPI shift register control FSM and the TX/RX data path, which use its strobes for load/unload and chip-select release.

## Interface
Parameters:
- BIT_W, 8: bits per word; legal range 2..32.
- MAX_WORDS, 16: maximum words per frame; legal range 2..256.
- Derived localparams: BCNT_W = clog2(BIT_W) and WCNT_W = clog2(MAX_WORDS). They are not overridable.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init  in  1  synchronous clear; returns the block to IDLE and zeroes all counters.
- start  in  1  begin a frame; honoured only in IDLE.
- cont  in  1  continuous mode; sampled at start and at each frame end.
- frame_len_m1  in  WCNT_W  words per frame minus one; latched at start and at each continuous restart.
- bit_tick  in  1  one SPI bit shifted this cycle.
- bit_cnt  out  BCNT_W  bits completed in the current word.
- word_cnt  out  WCNT_W  words completed in the current frame.
- busy  out  1  high in ACTIVE.
- last_word  out  1  level; high when busy and word_cnt equals the latched length.
- word_done  out  1  one-cycle strobe at each word boundary.
- frame_done  out  1  one-cycle strobe at each frame boundary.
- ovf  out  1  sticky error flag; present only under the macro.

## Operation
- FSM states: IDLE and ACTIVE.
  - IDLE -> ACTIVE on start. This transition latches frame_len_m1 into len_q and cont into cont_q, and zeroes both counters.
  - ACTIVE -> IDLE on the final bit of the final word when cont_q=0.
  - ACTIVE stays ACTIVE on that same event when cont_q=1. In that case len_q and cont_q re-latch from the live inputs and word_cnt returns to 0.
- In ACTIVE, each bit_tick increments bit_cnt.
  - When bit_cnt==BIT_W-1, bit_cnt wraps to 0, word_done pulses, and word_cnt increments.
  - On the word where word_cnt==len_q, word_cnt wraps to 0 instead and frame_done pulses together with word_done.
- bit_tick in IDLE is ignored, and the counters hold.
- start in ACTIVE is ignored.
- Priority, highest first: rst_n, then init, then start, then bit_tick.
  - If start and bit_tick coincide in IDLE, only the start is taken; the tick is dropped.
  - init in the same cycle as a final tick suppresses both strobes.
- All arithmetic is unsigned modulo the counter width.
  - frame_len_m1 is treated as a value in 0..MAX_WORDS-1.
  - frame_len_m1=0 gives a one-word frame.

## Timing
- Reset values: bit_cnt=0, word_cnt=0, busy=0, last_word=0, word_done=0, frame_done=0, ovf=0, state IDLE.
- start in cycle N gives busy=1 in cycle N+1.
- bit_tick in cycle N gives the updated bit_cnt in cycle N+1.
- word_done and frame_done are registered. They are high for exactly the single cycle N+1 after the terminal tick in cycle N.
- In one-shot mode, busy drops in the same cycle N+1 that frame_done is high.
- Back-to-back ticks on every cycle are supported with no bubbles, including across word and frame boundaries in continuous mode.
- last_word is combinational from registered state. It has no added latency.

## Configuration
- Macro: SPI_FRAME_CNT_OVF_EN.
- Defined:
  - ovf sets on any bit_tick received in IDLE, and on any start received in ACTIVE.
  - ovf is sticky until init or reset.
  - The counters are unaffected either way.
- Undefined: the ovf port and its register are absent, and the ignored events are silently dropped.

## Structure
- Shared package spi_cnt_pkg holds:
  - the state typedef (IDLE, ACTIVE);
  - a clog2 constant function;
  - default parameter constants SPI_BIT_W_DEF=8 and SPI_MAX_WORDS_DEF=16.
- One sub-module, spi_bit_counter: a modulo-BIT_W counter with enable, synchronous clear and a wrap output.
- The top level holds the FSM, the word counter, the length and mode latches, the strobe registers and the optional ovf logic.

## Test plan
- One-shot, BIT_W=8, frame_len_m1=2, 24 contiguous ticks:
  - word_done high in the cycles after ticks 8, 16 and 24;
  - frame_done only after tick 24;
  - busy=0 in the same cycle as frame_done;
  - a 25th tick leaves the counters at 0.
- Continuous, frame_len_m1=0, 16 ticks:
  - frame_done pulses twice;
  - busy stays 1 throughout.
- Change frame_len_m1 from 0 to 1 mid-frame:
  - the current frame ends with length 1;
  - the next frame is 2 words.
- Simultaneous events:
  - start and bit_tick in the same IDLE cycle: bit_cnt=0 the next cycle.
  - init on a terminal tick: no strobes, state IDLE.
- Assert rst_n low mid-word with bit_cnt=5: all outputs return to reset values asynchronously.
- With SPI_FRAME_CNT_OVF_EN defined:
  - a tick in IDLE sets ovf;
  - ovf holds through a subsequent frame;
  - init clears it.

Source files
------------

// File: rtl/spi_cnt_pkg.sv
// Shared types and constants for the SPI bit/word/frame counter.
// Holds the FSM state type, a constant clog2 and default geometry values.
package spi_cnt_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_cnt_state_e;

  localparam int SPI_BIT_W_DEF     = 8;
  localparam int SPI_MAX_WORDS_DEF = 16;

  // Bits needed to hold 0..value-1; value 1 still yields 1 bit so widths never collapse.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_frame_counter_if.sv
// Control and status bundle between the SPI shift FSM (master) and the frame counter (slave).
// The ovf status line exists only when SPI_FRAME_CNT_OVF_EN is defined.
interface spi_frame_counter_if
  import spi_cnt_pkg::*;
#(
  parameter int BIT_W     = SPI_BIT_W_DEF,
  parameter int MAX_WORDS = SPI_MAX_WORDS_DEF
);
  localparam int BCNT_W = clog2(BIT_W);
  localparam int WCNT_W = clog2(MAX_WORDS);

  logic              init;
  logic              start;
  logic              cont;
  logic [WCNT_W-1:0] frame_len_m1;
  logic              bit_tick;
  logic [BCNT_W-1:0] bit_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic              busy;
  logic              last_word;
  logic              word_done;
  logic              frame_done;
`ifdef SPI_FRAME_CNT_OVF_EN
  logic              ovf;
`endif

  modport master (
    output init, start, cont, frame_len_m1, bit_tick,
`ifdef SPI_FRAME_CNT_OVF_EN
    input  ovf,
`endif
    input  bit_cnt, word_cnt, busy, last_word, word_done, frame_done
  );

  modport slave (
    input  init, start, cont, frame_len_m1, bit_tick,
`ifdef SPI_FRAME_CNT_OVF_EN
    output ovf,
`endif
    output bit_cnt, word_cnt, busy, last_word, word_done, frame_done
  );

endinterface

// File: rtl/spi_bit_counter.sv
// Modulo-BIT_W bit counter with enable and synchronous clear.
// wrap is high in the cycle an enabled count steps from BIT_W-1 back to 0.
module spi_bit_counter
  import spi_cnt_pkg::*;
#(
  parameter  int BIT_W = SPI_BIT_W_DEF,
  localparam int CNT_W = clog2(BIT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_W - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_frame_counter.sv
// SPI bit/word/frame counter with registered word/frame strobes, one-shot or continuous.
// Optional sticky ovf flag for ignored tick/start events under SPI_FRAME_CNT_OVF_EN.
module spi_frame_counter
  import spi_cnt_pkg::*;
#(
  parameter int BIT_W     = SPI_BIT_W_DEF,
  parameter int MAX_WORDS = SPI_MAX_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_frame_counter_if.slave   bus
);

  localparam int BCNT_W = clog2(BIT_W);
  localparam int WCNT_W = clog2(MAX_WORDS);

  spi_cnt_state_e    state_q, state_d;
  logic [WCNT_W-1:0] word_cnt_q;
  logic [WCNT_W-1:0] len_q;
  logic              cont_q;
  logic              word_done_q;
  logic              frame_done_q;

  logic              is_idle;
  logic              is_active;
  logic              take_start;
  logic              tick_en;
  logic              word_end;
  logic              frame_end;
  logic [BCNT_W-1:0] bit_cnt;

  assign is_idle    = (state_q == IDLE);
  assign is_active  = (state_q == ACTIVE);
  assign take_start = is_idle && bus.start && !bus.init;
  assign tick_en    = is_active && bus.bit_tick && !bus.init;
  assign frame_end  = word_end && (word_cnt_q == len_q);

  spi_bit_counter #(
    .BIT_W (BIT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.init || take_start),
    .en    (tick_en),
    .count (bit_cnt),
    .wrap  (word_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.init) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.start) state_d = ACTIVE;
        ACTIVE:  if (frame_end && !cont_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A continuous frame end re-samples length and mode so the next frame can differ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      len_q      <= '0;
      cont_q     <= 1'b0;
    end else if (bus.init) begin
      word_cnt_q <= '0;
    end else if (take_start) begin
      word_cnt_q <= '0;
      len_q      <= bus.frame_len_m1;
      cont_q     <= bus.cont;
    end else if (frame_end) begin
      word_cnt_q <= '0;
      if (cont_q) begin
        len_q  <= bus.frame_len_m1;
        cont_q <= bus.cont;
      end
    end else if (word_end) begin
      word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      word_done_q  <= word_end;
      frame_done_q <= frame_end;
    end
  end

`ifdef SPI_FRAME_CNT_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.init) begin
      ovf_q <= 1'b0;
    end else if ((is_idle && bus.bit_tick) || (is_active && bus.start)) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.bit_cnt    = bit_cnt;
  assign bus.word_cnt   = word_cnt_q;
  assign bus.busy       = is_active;
  assign bus.last_word  = is_active && (word_cnt_q == len_q);
  assign bus.word_done  = word_done_q;
  assign bus.frame_done = frame_done_q;

endmodule
